// File: rtl/reg_file_2r1w_param.sv
// Register file: DEPTH x WIDTH, one write port, two registered read ports, bulk-clear sweep.
// Read latency 1 cycle; writes are dropped (wr_err pulse) while busy or out of range. Optional RF_BYPASS_EN forwarding.
// Backpressure: none; busy marks the DEPTH-cycle clear sweep, during which writes are refused.
module reg_file_2r1w_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_err
);

  localparam logic [ADDR_W:0]   DEPTH_W  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_PTR = DEPTH_W[ADDR_W-1:0] - 1'b1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, stateNext;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] sweepPtr;
  logic              wrInRange, wrIsZero, wrCommit, wrDrop;

  function automatic logic inRange(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  assign busy      = (state == CLEAR);
  assign wrInRange = inRange(wr_addr);
  assign wrIsZero  = ZERO_REG && (wr_addr == '0);
  assign wrCommit  = wr_en && !busy && wrInRange && !wrIsZero;
  // Hardwired entry 0 swallows writes without flagging them.
  assign wrDrop    = wr_en && (busy || !wrInRange) && !wrIsZero;

  function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    if (inRange(addr) && !(ZERO_REG && (addr == '0))) begin
      val = mem[addr];
`ifdef RF_BYPASS_EN
      if (wrCommit && (wr_addr == addr)) val = wr_data;
`endif
    end
    return val;
  endfunction

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (clr_req) stateNext = CLEAR;
      CLEAR:   if (sweepPtr == LAST_PTR) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sweepPtr <= '0;
    end else begin
      state <= stateNext;
      if (state == CLEAR) sweepPtr <= sweepPtr + 1'b1;
      else                sweepPtr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      wr_err    <= 1'b0;
    end else begin
      rd_data_a <= readPort(rd_addr_a);
      rd_data_b <= readPort(rd_addr_b);
      wr_err    <= wrDrop;
      // Sweep and commit are exclusive: a commit requires !busy.
      if (state == CLEAR) mem[sweepPtr] <= '0;
      else if (wrCommit)  mem[wr_addr]  <= wr_data;
    end
  end

endmodule
